// File: rtl/text_sequencer_if.sv
// text_sequencer_if: game-event inputs and overlay/timer control outputs of the
// text sequencer. The master drives events, the slave (the sequencer) drives controls.
interface text_sequencer_if;
  logic       refresh_tick;
  logic       btn_start;
  logic       btn_pause;
  logic       crash;
  logic       lap_done;
  logic       start_en;
  logic       crash_en;
  logic       finish_en;
  logic       pause;
  logic       timer_reset;
  logic       game_run;
  logic [2:0] state;

  modport master (
    output refresh_tick, btn_start, btn_pause, crash, lap_done,
    input  start_en, crash_en, finish_en, pause, timer_reset, game_run, state
  );

  modport slave (
    input  refresh_tick, btn_start, btn_pause, crash, lap_done,
    output start_en, crash_en, finish_en, pause, timer_reset, game_run, state
  );
endinterface

// File: rtl/text_sequencer.sv
// text_sequencer: game-flow FSM driving the text overlay banners and race timer.
// Optional start-banner blink in IDLE is enabled by defining TEXT_SEQ_BLINK_EN.
module text_sequencer #(
  parameter int unsigned READY_FRAMES = 120,
  parameter int unsigned END_FRAMES   = 180,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  text_sequencer_if.slave   bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    RACE   = 3'd2,
    PAUSED = 3'd3,
    CRASH  = 3'd4,
    FINISH = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic               start_prev_q, start_prev_d;
  logic               pause_prev_q, pause_prev_d;
  logic               start_rise_c, pause_rise_c;
  logic               idle_banner_c;

  logic start_en_q,    start_en_d;
  logic crash_en_q,    crash_en_d;
  logic finish_en_q,   finish_en_d;
  logic pause_q,       pause_d;
  logic timer_reset_q, timer_reset_d;
  logic game_run_q,    game_run_d;

  // Button rise detection against the previous sampled level
  always_comb begin
    start_prev_d = bus.btn_start;
    pause_prev_d = bus.btn_pause;
    start_rise_c = bus.btn_start & ~start_prev_q;
    pause_rise_c = bus.btn_pause & ~pause_prev_q;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_rise_c) state_d = READY;
      READY:  if (bus.refresh_tick && (fcnt_q == CNT_W'(READY_FRAMES - 1))) state_d = RACE;
      RACE: begin
        if (bus.crash)         state_d = CRASH;
        else if (bus.lap_done) state_d = FINISH;
        else if (pause_rise_c) state_d = PAUSED;
      end
      PAUSED: if (pause_rise_c) state_d = RACE;
      CRASH,
      FINISH: if (start_rise_c && (fcnt_q >= CNT_W'(END_FRAMES))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame counter: cleared on any state change, else counts ticks up to saturation
  always_comb begin
    fcnt_d = fcnt_q;
    if (state_d != state_q)
      fcnt_d = '0;
    else if (bus.refresh_tick && (fcnt_q != {CNT_W{1'b1}}))
      fcnt_d = fcnt_q + CNT_W'(1);
  end

`ifdef TEXT_SEQ_BLINK_EN
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q,  blink_on_d;

  // Blink phase advances only while staying in IDLE; restarts on-phase otherwise
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if ((state_q == IDLE) && (state_d == IDLE)) begin
      if (bus.refresh_tick) begin
        if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
      end
    end else begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end
    idle_banner_c = blink_on_d;
  end

  // Blink counter and phase registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`else
  logic [CNT_W-1:0] unused_blink_frames_c;

  // Steady banner in IDLE; blink length has no effect in this build
  always_comb begin
    idle_banner_c         = 1'b1;
    unused_blink_frames_c = CNT_W'(BLINK_FRAMES);
  end
`endif

  // Moore output decode of the next state, registered alongside the state
  always_comb begin
    start_en_d    = 1'b0;
    crash_en_d    = 1'b0;
    finish_en_d   = 1'b0;
    pause_d       = 1'b0;
    timer_reset_d = 1'b0;
    game_run_d    = 1'b0;
    case (state_d)
      IDLE: begin
        start_en_d    = idle_banner_c;
        pause_d       = 1'b1;
        timer_reset_d = 1'b1;
      end
      READY: begin
        start_en_d    = 1'b1;
        pause_d       = 1'b1;
        timer_reset_d = 1'b1;
      end
      RACE:   game_run_d = 1'b1;
      PAUSED: pause_d    = 1'b1;
      CRASH: begin
        crash_en_d = 1'b1;
        pause_d    = 1'b1;
      end
      FINISH: begin
        finish_en_d = 1'b1;
        pause_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter, button history and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fcnt_q        <= '0;
      start_prev_q  <= 1'b1;
      pause_prev_q  <= 1'b1;
      start_en_q    <= 1'b1;
      crash_en_q    <= 1'b0;
      finish_en_q   <= 1'b0;
      pause_q       <= 1'b1;
      timer_reset_q <= 1'b1;
      game_run_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      start_prev_q  <= start_prev_d;
      pause_prev_q  <= pause_prev_d;
      start_en_q    <= start_en_d;
      crash_en_q    <= crash_en_d;
      finish_en_q   <= finish_en_d;
      pause_q       <= pause_d;
      timer_reset_q <= timer_reset_d;
      game_run_q    <= game_run_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.start_en    = start_en_q;
  assign bus.crash_en    = crash_en_q;
  assign bus.finish_en   = finish_en_q;
  assign bus.pause       = pause_q;
  assign bus.timer_reset = timer_reset_q;
  assign bus.game_run    = game_run_q;

endmodule

// File: tb/tb_text_sequencer.sv
// tb_text_sequencer: scoreboard bench for the text sequencer game flow.
module tb_text_sequencer;

  localparam int unsigned READY_N = 120;
  localparam int unsigned END_N   = 180;
  localparam int unsigned BLINK_N = 2;
`ifdef TEXT_SEQ_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READY  = 3'd1;
  localparam logic [2:0] S_RACE   = 3'd2;
  localparam logic [2:0] S_PAUSED = 3'd3;
  localparam logic [2:0] S_CRASH  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  typedef struct {
    string      tag;
    logic [8:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  text_sequencer_if bus ();

  text_sequencer #(
    .READY_FRAMES (READY_N),
    .END_FRAMES   (END_N),
    .BLINK_FRAMES (BLINK_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected output word {state, start, crash, finish, pause, timer_reset, run}
  function automatic logic [8:0] exp_outs(input logic [2:0] st, input logic banner);
    case (st)
      S_IDLE:   return {S_IDLE,   banner, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      S_READY:  return {S_READY,  1'b1,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      S_RACE:   return {S_RACE,   1'b0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      S_PAUSED: return {S_PAUSED, 1'b0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      S_CRASH:  return {S_CRASH,  1'b0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      S_FINISH: return {S_FINISH, 1'b0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      default:  return 9'h1ff;
    endcase
  endfunction

  function automatic logic [8:0] observed();
    return {bus.state, bus.start_en, bus.crash_en, bus.finish_en,
            bus.pause, bus.timer_reset, bus.game_run};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, push the expectation, then pop and compare after the edge
  task automatic step(input string tag, input logic tk, input logic bs, input logic bp,
                      input logic cr, input logic ld, input logic [2:0] est, input logic banner);
    exp_t e;
    @(negedge clk);
    bus.refresh_tick = tk;
    bus.btn_start    = bs;
    bus.btn_pause    = bp;
    bus.crash        = cr;
    bus.lap_done     = ld;
    e.tag = tag;
    e.val = exp_outs(est, banner);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq(e.tag, 32'(observed()), 32'(e.val));
  endtask

  task automatic run_ready(input string tag);
    for (int i = 1; i <= int'(READY_N); i++)
      step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (i < int'(READY_N)) ? S_READY : S_RACE, 1'b1);
  endtask

  initial begin
    logic bl_pat [5];
    bl_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    bus.refresh_tick = 1'b0;
    bus.btn_start    = 1'b1;
    bus.btn_pause    = 1'b0;
    bus.crash        = 1'b0;
    bus.lap_done     = 1'b0;

    #12;
    check_eq("reset_vals", 32'(observed()), 32'(exp_outs(S_IDLE, 1'b1)));
    @(negedge clk);
    reset = 1'b0;

    // Start held through reset must not trigger
    step("hold_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
    step("start_low",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
    step("start_rise", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_READY, 1'b1);
    for (int i = 1; i <= int'(READY_N); i++) begin
      step("ready_gap",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_READY, 1'b1);
      step("ready_tick", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           (i < int'(READY_N)) ? S_READY : S_RACE, 1'b1);
    end

    // Pause toggling, events ignored while paused
    step("pause_rise",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_PAUSED, 1'b1);
    step("pause_hold",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_PAUSED, 1'b1);
    step("paused_crash", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_PAUSED, 1'b1);
    step("paused_lap",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_PAUSED, 1'b1);
    step("resume",       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_RACE, 1'b1);
    step("race_idle",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RACE, 1'b1);

    // Crash wins over lap_done; restart gated by END_N frames
    step("crash_lap",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_CRASH, 1'b1);
    step("crash_hold",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CRASH, 1'b1);
    for (int i = 0; i < 10; i++)
      step("crash_tick", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_CRASH, 1'b1);
    step("early_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_CRASH, 1'b1);
    step("early_rel",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CRASH, 1'b1);
    for (int i = 0; i < int'(END_N) - 11; i++)
      step("crash_tick", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_CRASH, 1'b1);
    step("start_179",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_CRASH, 1'b1);
    step("tick_180",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_CRASH, 1'b1);
    step("start_180",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);

    // Tick coinciding with READY entry is not counted
    step("idle_low",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
    step("rise_tick",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_READY, 1'b1);
    run_ready("ready2");

    // One-cycle lap pulse, then asynchronous reset mid-FINISH
    step("lap_pulse",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_FINISH, 1'b1);
    step("finish_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_FINISH, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst", 32'(observed()), 32'(exp_outs(S_IDLE, 1'b1)));
    @(negedge clk);
    reset = 1'b0;

    // Crash and pause rise together resolve to CRASH
    step("idle_low2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
    step("start_rise3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_READY, 1'b1);
    run_ready("ready3");
    step("crash_pause", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, S_CRASH, 1'b1);
    step("crash_hold2", 1'b0, 1'b0, 0, 1'b0, 1'b0, S_CRASH, 1'b1);

    // Start banner across IDLE frames, then steady in READY
    @(negedge clk);
    reset = 1'b1;
    bus.btn_start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step("blink_f0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
    for (int k = 1; k < 5; k++)
      step("blink_f", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_IDLE, BLINK_ON ? bl_pat[k] : 1'b1);
    step("blink_low",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b1);
    step("blink_rise", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_READY, 1'b1);
    for (int k = 0; k < 3; k++)
      step("ready_steady", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_READY, 1'b1);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_sequencer.md
# text_sequencer

Game-flow controller for the text overlay and race timer. It sequences the start banner, the crash and finish messages, and the timer's pause and reset controls from player buttons and game events. It sits between the input/collision logic and the text overlay block, driving its `start_en`, `crash_en`, `finish_en`, `pause` and timer `reset` inputs. Frame-based holds are counted on `refresh_tick`.

## Interface
Parameters:
- `READY_FRAMES`, default 120: frames shown in READY before the race starts. Legal range 1–255.
- `END_FRAMES`, default 180: minimum frames a crash or finish message is held before restart is accepted. Legal range 1–255.
- `BLINK_FRAMES`, default 30: half-period of the start-banner blink, in frames. Used only with `TEXT_SEQ_BLINK_EN`. Legal range 1–255.

Ports:
- `clk` input, 1: system clock. This is the only clock.
- `reset` input, 1: asynchronous, active-high reset.
- `refresh_tick` input, 1: one-cycle pulse, once per video frame.
- `btn_start` input, 1: start/restart button, synchronized level.
- `btn_pause` input, 1: pause toggle button, synchronized level.
- `crash` input, 1: collision detected, level or pulse.
- `lap_done` input, 1: finish line crossed, level or pulse.
- `start_en` output, 1: show the start banner.
- `crash_en` output, 1: show the crash message.
- `finish_en` output, 1: show the finish message.
- `pause` output, 1: freeze the race timer.
- `timer_reset` output, 1: hold the race timer at zero.
- `game_run` output, 1: car and track motion enabled.
- `state` output, 3: current state encoding, for debug and LEDs.

## Operation
State encodings: IDLE=0, READY=1, RACE=2, PAUSED=3, CRASH=4, FINISH=5. Codes 6–7 are illegal and return to IDLE on the next clock.

Button edge detection:
- `btn_start` and `btn_pause` are registered into prev-value flops.
- A rise is defined as `in & ~prev`.
- The prev flops reset to 1, so a button held through reset does not trigger.

8-bit frame counter `fcnt`:
- Clears on every state change.
- Otherwise increments on `refresh_tick`, saturating at 255.

Transitions:
- IDLE: start rise → READY.
- READY: `refresh_tick` with `fcnt == READY_FRAMES-1` → RACE.
- RACE: priority is `crash` → CRASH, then `lap_done` → FINISH, then pause rise → PAUSED.
- PAUSED: pause rise → RACE. `crash` and `lap_done` are ignored.
- CRASH and FINISH: start rise with `fcnt >= END_FRAMES` → IDLE. Earlier start rises are ignored and not remembered.

Output decode is Moore, from the state register only, with no input-to-output combinational path:
- IDLE: `start_en`=1 (or blink), `pause`=1, `timer_reset`=1.
- READY: `start_en`=1, `pause`=1, `timer_reset`=1.
- RACE: `game_run`=1. All others 0.
- PAUSED: `pause`=1.
- CRASH: `crash_en`=1, `pause`=1.
- FINISH: `finish_en`=1, `pause`=1.
- At most one of `start_en`, `crash_en`, `finish_en` is ever high.

## Timing
- Reset values: `state`=IDLE (0), `start_en`=1, `pause`=1, `timer_reset`=1, `crash_en`=0, `finish_en`=0, `game_run`=0, `fcnt`=0, blink phase on.
- Latency: an input edge sampled at rising clock N gives new state and outputs after clock N, i.e. one-cycle latency.
- READY lasts exactly `READY_FRAMES` refresh ticks. The tick that completes the count moves the FSM to RACE on that same clock.
- `crash` and `lap_done` are sampled every cycle in RACE. A one-cycle pulse is sufficient.
- Simultaneous `crash` and `lap_done` in RACE → CRASH.
- Simultaneous `crash` and pause rise in RACE → CRASH.
- A `refresh_tick` coinciding with a state change is not counted in the new state.
- `reset` asserted mid-game forces IDLE immediately, asynchronously. Release is synchronous to `clk`.

## Configuration
- `TEXT_SEQ_BLINK_EN` defined: in IDLE only, `start_en` toggles every `BLINK_FRAMES` refresh ticks.
  - The blink counter and phase reset on IDLE entry, with phase on.
  - READY shows a steady `start_en`=1.
- `TEXT_SEQ_BLINK_EN` undefined: `start_en` is steady 1 in IDLE and no blink logic is synthesized.

## Test plan
- Reset release with `btn_start` held high → stays IDLE. `start_en`=1, `timer_reset`=1, `pause`=1.
- Start rise → READY next cycle. After 120 `refresh_tick` pulses → RACE, with `game_run`=1, `pause`=0, `timer_reset`=0, `start_en`=0.
- In RACE, pause rise → PAUSED with `pause`=1 and `game_run`=0. A `crash` pulse while paused is ignored. A second pause rise → RACE.
- In RACE, `crash` and `lap_done` asserted in the same cycle → CRASH with `crash_en`=1 and `finish_en`=0.
  - Start rise after 10 frames → still CRASH.
  - Start rise after 180 frames → IDLE.
- In RACE, 1-cycle `lap_done` → FINISH with `finish_en`=1, `pause`=1. Assert `reset` mid-FINISH → immediately IDLE with reset values on all outputs.
- With `TEXT_SEQ_BLINK_EN` and `BLINK_FRAMES`=2: in IDLE, `start_en` reads 1,1,0,0,1 across successive frames. In READY, `start_en` is steady 1.
